// File: rtl/bus_mem_io_resp_if.sv
// bus_mem_io_resp_if: CPU data-side load/store bus between top_cpu (master) and the responder (slave).
interface bus_mem_io_resp_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] ram_indata;
  logic        ram_ready;
  logic        bus_err;
  modport master (output bus_addr, bus_wdata, bus_we, bus_re, input ram_indata, ram_ready, bus_err);
  modport slave  (input bus_addr, bus_wdata, bus_we, bus_re, output ram_indata, ram_ready, bus_err);
endinterface

// File: rtl/bus_mem_io_resp.sv
// bus_mem_io_resp: data RAM, LED and 7-segment registers behind the CPU load/store bus.
// Define BUS_ERR_EN to add the unmapped-access pulse and sticky error register at 0xFFFF_000C.
module bus_mem_io_resp #(
  parameter int RAM_AW   = 6,
  parameter int SCAN_DIV = 50000,
  parameter int LED_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  bus_mem_io_resp_if.slave bus,
  output logic [LED_W-1:0] led,
  output logic [7:0]       seg,
  output logic [3:0]       an
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [31:0]      r_ram [2**RAM_AW];
  logic [LED_W-1:0] r_led;
  logic [15:0]      r_seg;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_idx;
  logic [31:0]      r_rdata;
  logic             r_ready;
  logic [29:0]      w_word;
  logic             w_is_ram, w_is_led, w_is_seg, w_is_scan, w_is_errr;
  logic [31:0]      w_sticky, w_rdata;
  logic [3:0]       w_digit;

  function automatic logic [7:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 8'hC0; 4'h1: hex7 = 8'hF9; 4'h2: hex7 = 8'hA4; 4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h92; 4'h6: hex7 = 8'h82; 4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80; 4'h9: hex7 = 8'h90; 4'hA: hex7 = 8'h88; 4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6; 4'hD: hex7 = 8'hA1; 4'hE: hex7 = 8'h86; default: hex7 = 8'h8E;
    endcase
  endfunction

  assign w_word    = bus.bus_addr[31:2];
  assign w_is_ram  = bus.bus_addr[31:RAM_AW+2] == '0;
  assign w_is_led  = w_word == 30'h3FFF_C000;
  assign w_is_seg  = w_word == 30'h3FFF_C001;
  assign w_is_scan = w_word == 30'h3FFF_C002;

`ifdef BUS_ERR_EN
  logic r_err, r_sticky, w_bad;
  assign w_is_errr   = w_word == 30'h3FFF_C003;
  assign w_sticky    = {31'b0, r_sticky};
  assign bus.bus_err = r_err;
  assign w_bad = (bus.bus_re | bus.bus_we) & ~(w_is_ram | w_is_led | w_is_seg | w_is_scan | w_is_errr);
  // a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_err    <= w_bad;
      r_sticky <= w_bad | (r_sticky & ~(bus.bus_we & w_is_errr));
    end
  end
`else
  assign w_is_errr   = 1'b0;
  assign w_sticky    = '0;
  assign bus.bus_err = 1'b0;
`endif

  always_comb
    w_rdata = w_is_ram  ? r_ram[bus.bus_addr[RAM_AW+1:2]] :
              w_is_led  ? 32'(r_led) :
              w_is_seg  ? {16'b0, r_seg} :
              w_is_scan ? {30'b0, r_idx} :
              w_is_errr ? w_sticky : 32'b0;

  always_ff @(posedge clk)
    if (bus.bus_we && w_is_ram) r_ram[bus.bus_addr[RAM_AW+1:2]] <= bus.bus_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led   <= '0;
      r_seg   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      if (bus.bus_we && w_is_led) r_led <= bus.bus_wdata[LED_W-1:0];
      if (bus.bus_we && w_is_seg) r_seg <= bus.bus_wdata[15:0];
      r_cnt   <= (r_cnt == CW'(SCAN_DIV - 1)) ? '0 : r_cnt + 1'b1;
      r_idx   <= (r_cnt == CW'(SCAN_DIV - 1)) ? r_idx + 1'b1 : r_idx;
      r_ready <= bus.bus_re;
      if (bus.bus_re) r_rdata <= w_rdata;
    end
  end

  assign w_digit        = r_seg[{r_idx, 2'b00} +: 4];
  assign seg            = hex7(w_digit);
  assign an             = ~(4'b0001 << r_idx);
  assign led            = r_led;
  assign bus.ram_indata = r_rdata;
  assign bus.ram_ready  = r_ready;
endmodule
